// File: rtl/spi_rx_stream.sv
// spi_rx_stream: SPI slave receive path with a first-word fall-through output FIFO.
// SCS/SCK/SDI are synchronised into clk. Each complete DATA_W-bit word is pushed
// into a FIFO_DEPTH-entry FIFO that has a valid/ready head.
// Optional feature macro: SPI_RX_STREAM_ERR_EN builds the overrun_o and abort_o logic.
// Without the macro, both outputs are tied low, clr_i is ignored, and a push into a
// full FIFO is dropped silently.
module spi_rx_stream #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scs_i,
    input  logic                          sck_i,
    input  logic                          sdi_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          abort_o,
    input  logic                          clr_i
);

    localparam int   CNT_W       = $clog2(DATA_W);
    localparam int   PTR_W       = $clog2(FIFO_DEPTH);
    localparam int   LVL_W       = PTR_W + 1;
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    logic [SYNC_STAGES-1:0] scs_sync_q, sck_sync_q, sdi_sync_q;
    logic                   scs_s, sck_s, sdi_s;
    logic                   sck_dly_q;
    logic                   aligned_q, aligned_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      word_next;
    logic                   sample, last_bit, push;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   pop, full, wr_en, drop;

    // Synchroniser chains. The edge detector and data tap share the last stage,
    // so SDI is aligned with the SCK edge that samples it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scs_sync_q <= '0;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_dly_q  <= 1'b0;
        end else begin
            scs_sync_q <= {scs_sync_q[SYNC_STAGES-2:0], scs_i};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
            sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign scs_s = scs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // After reset the receiver stays deaf until SCS is seen high.
    // This prevents it from locking onto the middle of a frame.
    assign sample    = aligned_q && !scs_s && (sck_s != sck_dly_q) && (sck_s == SAMPLE_RISE);
    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign push      = sample && last_bit;
    assign word_next = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], sdi_s}
                                        : {sdi_s, shift_q[DATA_W-1:1]};
    assign busy_o    = aligned_q && !scs_s;

    // Deserialiser next state: an idle chip select holds the bit counter at zero.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        aligned_d = aligned_q | scs_s;
        if (scs_s) begin
            bit_cnt_d = '0;
        end else if (sample) begin
            shift_d   = word_next;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
        end
    end

    // Deserialiser state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            aligned_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            aligned_q <= aligned_d;
        end
    end

    // A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
    assign valid_o = (level_q != '0);
    assign pop     = valid_o && ready_i;
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
    assign level_o = level_q;

    // FIFO pointer and occupancy next state. Pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage. Stale entries are never visible, so the storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= word_next;
        end
    end

`ifdef SPI_RX_STREAM_ERR_EN
    logic scs_dly_q;
    logic overrun_q, overrun_d;
    logic abort_q, abort_d;

    // Error flags. A drop wins over a clear that arrives in the same cycle.
    always_comb begin
        abort_d   = scs_s && !scs_dly_q && (bit_cnt_q != '0);
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scs_dly_q <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            scs_dly_q <= scs_s;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign overrun_o = overrun_q;
    assign abort_o   = abort_q;
`else
    logic unused_err;
    assign unused_err = &{1'b0, clr_i, drop};
    assign overrun_o  = 1'b0;
    assign abort_o    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_stream.sv
// Bench for spi_rx_stream: five instances cover all CPOL/CPHA modes plus LSB-first order.
// Instance 0 (mode 0, MSB-first) exercises the FIFO, overrun, abort and reset behaviour.
module tb_spi_rx_stream;

`ifdef SPI_RX_STREAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int NI = 5;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scs = 1'b1;
    logic        sdi = 1'b0;
    logic        clr = 1'b0;
    logic        sck      [NI];
    logic        rdy      [NI];
    logic [31:0] data_a   [NI];
    logic        valid_a  [NI];
    logic [2:0]  level_a  [NI];
    logic        busy_a   [NI];
    logic        ovr_a    [NI];
    logic        abort_a  [NI];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_edge_cyc = 0;
    int rise_cyc = 0;
    int abort_cnt = 0;
    int pops [NI];
    logic [31:0] last_pop [NI];
    logic vprev0 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P_CPOL = (g == 2 || g == 3) ? 1 : 0;
        localparam int P_CPHA = (g == 1 || g == 3) ? 1 : 0;
        localparam int P_MSB  = (g == 4) ? 0 : 1;
        spi_rx_stream #(
            .DATA_W(32), .FIFO_DEPTH(4), .CPOL(P_CPOL), .CPHA(P_CPHA),
            .MSB_FIRST(P_MSB), .SYNC_STAGES(SS)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .scs_i(scs), .sck_i(sck[g]), .sdi_i(sdi),
            .data_o(data_a[g]), .valid_o(valid_a[g]), .ready_i(rdy[g]),
            .level_o(level_a[g]), .busy_o(busy_a[g]), .overrun_o(ovr_a[g]),
            .abort_o(abort_a[g]), .clr_i(clr)
        );
    end

    // Monitor: looks just after each falling edge, when inputs for the next rising edge are settled.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (valid_a[i] && rdy[i]) begin
                pops[i]     <= pops[i] + 1;
                last_pop[i] <= data_a[i];
            end
        end
        if (valid_a[0] && !vprev0) rise_cyc <= cyc;
        vprev0 <= valid_a[0];
        if (abort_a[0]) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit cpol_of(input int inst);
        return (inst == 2 || inst == 3);
    endfunction

    function automatic bit cpha_of(input int inst);
        return (inst == 1 || inst == 3);
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Transmits the first nbits of w, starting with w[31].
    // With pop_sync set, ready is raised for exactly the cycle in which the last bit is pushed.
    task automatic send_bits(input int inst, input logic [31:0] w, input int nbits, input bit pop_sync);
        bit pol, pha;
        pol = cpol_of(inst);
        pha = cpha_of(inst);
        for (int b = 0; b < nbits; b++) begin
            if (!pha) begin
                sdi = w[31-b];
                half();
                sck[inst] = ~pol;
                last_edge_cyc = cyc;
                if (pop_sync && b == nbits - 1) begin
                    @(negedge clk);
                    @(negedge clk);
                    rdy[0] = 1'b1;
                    @(negedge clk);
                    rdy[0] = 1'b0;
                    @(negedge clk);
                end else begin
                    half();
                end
                sck[inst] = pol;
            end else begin
                sck[inst] = ~pol;
                sdi = w[31-b];
                half();
                sck[inst] = pol;
                last_edge_cyc = cyc;
                half();
            end
        end
    endtask

    task automatic frame(input int inst, input logic [31:0] w, input bit pop_sync);
        scs = 1'b0;
        half();
        send_bits(inst, w, 32, pop_sync);
        half();
        scs = 1'b1;
        half();
        half();
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_vld"}, valid_a[0], 1);
        chk({tag, "_dat"}, data_a[0], exp);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] w, wl[5];
    bit exp_ovr;
    int p0, a0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            sck[i]  = cpol_of(i);
            rdy[i]  = (i != 0);
            pops[i] = 0;
        end
        repeat (4) @(negedge clk);
        chk("rst_data", data_a[0], 0);
        chk("rst_valid", valid_a[0], 0);
        chk("rst_level", level_a[0], 0);
        chk("rst_busy", busy_a[0], 0);
        chk("rst_ovr", ovr_a[0], 0);
        chk("rst_abort", abort_a[0], 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Mode 0, MSB-first: one valid cycle per word, bounded pin-to-valid latency.
        rdy[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 32'hA5C3_0F96 : $urandom;
            p0 = pops[0];
            frame(0, w, 1'b0);
            chk("m0_npop", pops[0] - p0, 1);
            chk("m0_data", last_pop[0], w);
            chk($sformatf("m0_lat%0d", rise_cyc - last_edge_cyc),
                (rise_cyc - last_edge_cyc >= SS + 1) && (rise_cyc - last_edge_cyc <= SS + 2), 1);
        end
        rdy[0] = 1'b0;

        // Other modes and LSB-first order.
        for (int inst = 1; inst < NI; inst++) begin
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? 32'h0000_0001 : $urandom;
                p0 = pops[inst];
                frame(inst, w, 1'b0);
                chk($sformatf("mode%0d_npop", inst), pops[inst] - p0, 1);
                chk($sformatf("mode%0d_data", inst), last_pop[inst], (inst == 4) ? bitrev(w) : w);
            end
        end

        // Five words into a four-entry FIFO with the consumer stalled.
        q.delete();
        exp_ovr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wl[k] = $urandom;
            frame(0, wl[k], 1'b0);
            if (q.size() < 4) q.push_back(wl[k]);
            else exp_ovr = ERR_EN;
        end
        chk("ovf_level", level_a[0], 4);
        chk("ovf_flag", ovr_a[0], exp_ovr);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_clr", ovr_a[0], 0);
        while (q.size() > 0) pop_chk("ovf_pop", q.pop_front());
        chk("ovf_empty", level_a[0], 0);
        chk("ovf_data0", data_a[0], 0);

        // Aborted frame after 13 bits, then a complete frame.
        a0 = abort_cnt;
        p0 = pops[0];
        rdy[0] = 1'b1;
        scs = 1'b0;
        half();
        chk("abt_busy", busy_a[0], 1);
        send_bits(0, $urandom, 13, 1'b0);
        half();
        scs = 1'b1;
        half();
        half();
        chk("abt_pulse", abort_cnt - a0, ERR_EN ? 1 : 0);
        chk("abt_nopop", pops[0] - p0, 0);
        frame(0, 32'h1234_5678, 1'b0);
        chk("abt_npop", pops[0] - p0, 1);
        chk("abt_data", last_pop[0], 32'h1234_5678);
        chk("abt_once", abort_cnt - a0, ERR_EN ? 1 : 0);
        rdy[0] = 1'b0;

        // Full FIFO with a push and a pop in the same cycle.
        for (int k = 0; k < 5; k++) wl[k] = $urandom;
        for (int k = 0; k < 4; k++) frame(0, wl[k], 1'b0);
        chk("sim_full", level_a[0], 4);
        p0 = pops[0];
        frame(0, wl[4], 1'b1);
        chk("sim_npop", pops[0] - p0, 1);
        chk("sim_popdat", last_pop[0], wl[0]);
        chk("sim_level", level_a[0], 4);
        chk("sim_noovr", ovr_a[0], 0);
        for (int k = 1; k < 5; k++) pop_chk("sim_pop", wl[k]);

        // Reset mid-word with two words queued, then re-alignment on SCS high.
        frame(0, $urandom, 1'b0);
        frame(0, $urandom, 1'b0);
        chk("rmw_level2", level_a[0], 2);
        scs = 1'b0;
        half();
        send_bits(0, $urandom, 10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rmw_level", level_a[0], 0);
        chk("rmw_valid", valid_a[0], 0);
        chk("rmw_data", data_a[0], 0);
        send_bits(0, $urandom, 32, 1'b0);
        half();
        chk("rmw_deaf", level_a[0], 0);
        a0 = abort_cnt;
        scs = 1'b1;
        half();
        half();
        chk("rmw_noabt", abort_cnt - a0, 0);
        w = $urandom;
        frame(0, w, 1'b0);
        chk("rmw_level1", level_a[0], 1);
        pop_chk("rmw_pop", w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
